// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer; shares the memory port with a debug master.
// Define MEM_TIMEOUT_EN to bound the ack wait and enable the sticky mem_err flag.
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead_EX_MEM,
  input  logic              memWrite_EX_MEM,
  input  logic [DATA_W-1:0] aluResult_EX_MEM,
  input  logic [DATA_W-1:0] data2_EX_MEM,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] readData_MEM,
  output logic              mem_err
);

  typedef enum logic [2:0] {
    IDLE,
    PIPE_ACC,
    PIPE_DONE,
    DBG_ACC,
    DBG_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              we_q, we_d;
  logic              pipe_op;
  logic              acc;
  logic              tmo;

  assign pipe_op = memRead_EX_MEM | memWrite_EX_MEM;
  assign acc     = (state_q == PIPE_ACC) |
                   (state_q == DBG_ACC);

`ifdef MEM_TIMEOUT_EN
  localparam int CW_MIN = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_MIN > 8) ? CW_MIN : 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter is zero on every entry to an access state.
  assign tmo = acc & ~mem_ack &
               (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (acc) cnt_d = cnt_q + 1'b1;
  end

  assign err_d   = err_q | tmo;
  assign mem_err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo     = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    drdata_d = drdata_q;
    unique case (state_q)
      IDLE: begin
        if (pipe_op) begin
          state_d = PIPE_ACC;
          addr_d  = aluResult_EX_MEM;
          wdata_d = data2_EX_MEM;
          we_d    = memWrite_EX_MEM;
        end else if (dbg_req) begin
          state_d = DBG_ACC;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          we_d    = dbg_we;
        end
      end
      PIPE_ACC: begin
        if (mem_ack) begin
          state_d = PIPE_DONE;
          rdata_d = mem_rdata;
        end else if (tmo) begin
          state_d = PIPE_DONE;
          rdata_d = '0;
        end
      end
      DBG_ACC: begin
        if (mem_ack) begin
          state_d  = DBG_DONE;
          drdata_d = mem_rdata;
        end else if (tmo) begin
          state_d  = DBG_DONE;
          drdata_d = '0;
        end
      end
      // Always return to IDLE so an EX/MEM entry is never reissued.
      PIPE_DONE: state_d = IDLE;
      DBG_DONE:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign mem_req      = acc;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign readData_MEM = rdata_q;
  assign dbg_rdata    = drdata_q;
  assign dbg_ack      = (state_q == DBG_DONE);
  assign stall        = pipe_op & (state_q != PIPE_DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: latency-programmable memory responder,
// directed scenarios and randomized traffic against a word-array model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead_EX_MEM, memWrite_EX_MEM;
  logic [31:0] aluResult_EX_MEM, data2_EX_MEM;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [31:0] readData_MEM;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  // responder: mode 0 normal, 1 never acks, 2 acks every cycle
  int          mode = 0;
  int          lat_cfg = 0;
  int          wcnt = 0;
  bit          busy = 0;
  logic [31:0] dmem    [0:63];
  logic [31:0] ref_mem [0:63];

  mem_access_ctrl #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .memRead_EX_MEM(memRead_EX_MEM),
    .memWrite_EX_MEM(memWrite_EX_MEM),
    .aluResult_EX_MEM(aluResult_EX_MEM),
    .data2_EX_MEM(data2_EX_MEM),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .readData_MEM(readData_MEM),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mode == 2) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      busy      = 0;
    end else if (mode == 0 && mem_req) begin
      if (!busy) begin
        busy = 1;
        wcnt = lat_cfg;
      end
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = dmem[mem_addr[7:2]];
        if (mem_we) dmem[mem_addr[7:2]] = mem_wdata;
        busy = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt--;
      end
    end else begin
      mem_ack = 1'b0;
      busy    = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic pipe_acc(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int lat);
    int cyc;
    int reqc;
    cyc  = 0;
    reqc = 0;
    lat_cfg          = lat;
    memRead_EX_MEM   = rd;
    memWrite_EX_MEM  = wr;
    aluResult_EX_MEM = a;
    data2_EX_MEM     = d;
    #1;
    while (stall && cyc < 200) begin
      cyc++;
      if (mem_req) begin
        reqc++;
        chk("pipe_mem_we", {31'b0, mem_we}, {31'b0, wr});
        chk("pipe_mem_addr", mem_addr, a);
        if (wr) chk("pipe_mem_wdata", mem_wdata, d);
      end
      @(negedge clk);
      #1;
    end
    chk("pipe_stall_cycles", 32'(cyc), 32'(lat + 2));
    chk("pipe_req_cycles", 32'(reqc), 32'(lat + 1));
    if (!wr) chk("pipe_readData", readData_MEM, ref_mem[a[7:2]]);
    else ref_mem[a[7:2]] = d;
    @(negedge clk);
    memRead_EX_MEM  = 1'b0;
    memWrite_EX_MEM = 1'b0;
  endtask

  task automatic dbg_acc(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int lat);
    int cyc;
    cyc       = 0;
    lat_cfg   = lat;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = d;
    #1;
    while (!dbg_ack && cyc < 200) begin
      cyc++;
      chk("dbg_no_stall", {31'b0, stall}, 32'd0);
      if (mem_req) begin
        chk("dbg_mem_we", {31'b0, mem_we}, {31'b0, we});
        chk("dbg_mem_addr", mem_addr, a);
      end
      @(negedge clk);
      #1;
    end
    chk("dbg_latency", 32'(cyc), 32'(lat + 2));
    if (!we) chk("dbg_rdata", dbg_rdata, ref_mem[a[7:2]]);
    else ref_mem[a[7:2]] = d;
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    chk("dbg_ack_one_cycle", {31'b0, dbg_ack}, 32'd0);
  endtask

  initial begin
    int cyc;
    int reqc;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] old;
    for (int i = 0; i < 64; i++) begin
      dmem[i]    = {24'hA5A5A5, 8'(i)};
      ref_mem[i] = {24'hA5A5A5, 8'(i)};
    end
    mem_ack = 1'b0;
    mem_rdata = '0;
    reset = 1'b0;
    memRead_EX_MEM = 1'b0;
    memWrite_EX_MEM = 1'b0;
    aluResult_EX_MEM = '0;
    data2_EX_MEM = '0;
    dbg_req = 1'b0;
    dbg_we = 1'b0;
    dbg_addr = '0;
    dbg_wdata = '0;

    // reset values
    #2;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_readData", readData_MEM, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_stall_noop", {31'b0, stall}, 32'd0);
    memRead_EX_MEM = 1'b1;
    #1;
    chk("rst_stall_op", {31'b0, stall}, 32'd1);
    memRead_EX_MEM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // load 0x40 with 3 wait cycles, store with immediate ack
    dbg_acc(1'b1, 32'h40, 32'h1234ABCD, 0);
    pipe_acc(1'b1, 1'b0, 32'h40, 32'h0, 3);
    chk("load_0x40", readData_MEM, 32'h1234ABCD);
    pipe_acc(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 0);
    pipe_acc(1'b1, 1'b0, 32'h80, 32'h0, 1);
    // read+write together is a single write
    pipe_acc(1'b1, 1'b1, 32'h84, 32'h55AA1234, 1);
    dbg_acc(1'b0, 32'h84, 32'h0, 0);

    // pipeline load arrives during a debug read of 0x10
    lat_cfg   = 2;
    dbg_req   = 1'b1;
    dbg_we    = 1'b0;
    dbg_addr  = 32'h10;
    @(negedge clk);
    memRead_EX_MEM   = 1'b1;
    aluResult_EX_MEM = 32'h44;
    cyc = 0;
    #1;
    while (!dbg_ack && cyc < 200) begin
      cyc++;
      chk("coll_stall_dbg", {31'b0, stall}, 32'd1);
      @(negedge clk);
      #1;
    end
    chk("coll_dbg_rdata", dbg_rdata, ref_mem[4]);
    chk("coll_stall_at_ack", {31'b0, stall}, 32'd1);
    @(negedge clk);
    dbg_req = 1'b0;
    cyc = 0;
    #1;
    while (stall && cyc < 200) begin
      cyc++;
      if (mem_req) chk("coll_pipe_addr", mem_addr, 32'h44);
      @(negedge clk);
      #1;
    end
    chk("coll_pipe_cycles", 32'(cyc), 32'd4);
    chk("coll_pipe_data", readData_MEM, ref_mem[17]);
    @(negedge clk);
    memRead_EX_MEM = 1'b0;

    // simultaneous requests: pipeline wins, debug write waits
    old = ref_mem[8];
    lat_cfg          = 1;
    dbg_req          = 1'b1;
    dbg_we           = 1'b1;
    dbg_addr         = 32'h20;
    dbg_wdata        = 32'h0BADF00D;
    memRead_EX_MEM   = 1'b1;
    aluResult_EX_MEM = 32'h20;
    cyc = 0;
    #1;
    while (stall && cyc < 200) begin
      cyc++;
      chk("simul_no_dbg_ack", {31'b0, dbg_ack}, 32'd0);
      @(negedge clk);
      #1;
    end
    chk("simul_pipe_cycles", 32'(cyc), 32'd3);
    chk("simul_pipe_old", readData_MEM, old);
    @(negedge clk);
    memRead_EX_MEM = 1'b0;
    cyc = 0;
    #1;
    while (!dbg_ack && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("simul_dbg_cycles", 32'(cyc), 32'd3);
    ref_mem[8] = 32'h0BADF00D;
    @(negedge clk);
    dbg_req = 1'b0;
    pipe_acc(1'b1, 1'b0, 32'h20, 32'h0, 0);

    // randomized mixed traffic
    for (int n = 0; n < 30; n++) begin
      int k;
      int l;
      k = $urandom_range(0, 4);
      l = $urandom_range(0, 4);
      a = 32'($urandom_range(0, 63)) << 2;
      d = $urandom;
      case (k)
        0: pipe_acc(1'b1, 1'b0, a, d, l);
        1: pipe_acc(1'b0, 1'b1, a, d, l);
        2: pipe_acc(1'b1, 1'b1, a, d, l);
        3: dbg_acc(1'b0, a, d, l);
        default: dbg_acc(1'b1, a, d, l);
      endcase
    end
    chk("rand_mem_err", {31'b0, mem_err}, 32'd0);

    // no ack from memory
    mode             = 1;
    memRead_EX_MEM   = 1'b1;
    aluResult_EX_MEM = 32'h50;
`ifdef MEM_TIMEOUT_EN
    cyc  = 0;
    reqc = 0;
    #1;
    while (stall && cyc < 200) begin
      cyc++;
      if (mem_req) reqc++;
      @(negedge clk);
      #1;
    end
    chk("tmo_req_cycles", 32'(reqc), 32'd4);
    chk("tmo_stall_cycles", 32'(cyc), 32'd5);
    chk("tmo_readData", readData_MEM, 32'd0);
    chk("tmo_err", {31'b0, mem_err}, 32'd1);
    @(negedge clk);
    memRead_EX_MEM = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_err_sticky", {31'b0, mem_err}, 32'd1);
    memRead_EX_MEM   = 1'b1;
    aluResult_EX_MEM = 32'h54;
    @(negedge clk);
    #1;
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
`else
    repeat (1000) @(negedge clk);
    #1;
    chk("hang_req", {31'b0, mem_req}, 32'd1);
    chk("hang_stall", {31'b0, stall}, 32'd1);
    chk("hang_err", {31'b0, mem_err}, 32'd0);
`endif

    // reset in the middle of a pipeline access
    reset          = 1'b0;
    memRead_EX_MEM = 1'b0;
    #1;
    chk("abort_req", {31'b0, mem_req}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_err", {31'b0, mem_err}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    mode = 2;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("stray_req", {31'b0, mem_req}, 32'd0);
    chk("stray_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    chk("stray_readData", readData_MEM, 32'd0);
    chk("stray_stall", {31'b0, stall}, 32'd0);
    mode = 0;
    @(negedge clk);
    pipe_acc(1'b1, 1'b0, 32'h40, 32'h0, 2);
    chk("post_rst_load", readData_MEM, 32'h1234ABCD);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
